// File: rtl/bch_frame_ctrl.sv
// Sequencing controller for a serial BCH decode chain (syndrome -> key solver -> locator).
// Accepts serial codewords and forwards them to the syndrome unit. Buffers the K data bits of
// up to SLOTS in-flight frames and XORs the locator's error stream onto them to produce
// corrected serial output. Frames are processed strictly in order.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   in_start_i, in_data_i   serial codeword input (data bits 0..K-1 first), in_busy_o back-pressure
//   syn_start_o, syn_data_o start and serial data toward the syndrome unit
//   syn_done_i              syndromes ready
//   key_start_o             accept syndromes / start the key solver
//   key_busy_i              key solver busy
//   key_done_i              sigma ready
//   key_err_count_i         error count of the frame finishing key solve
//   err_start_o             accept sigma / start the locator
//   err_busy_i              locator busy
//   err_ready_i             error flag for data bit 0
//   err_valid_i             error flags for data bits 1..K-1
//   err_i                   error flag
//   out_valid_o, out_data_o corrected data bit stream
//   out_first_o/out_last_o  frame delimiters
//   out_err_count_o         error count, valid with out_first_o
//   fault_o                 sticky protocol/overflow flag
module bch_frame_ctrl #(
  parameter int unsigned N     = 15,
  parameter int unsigned K     = 5,
  parameter int unsigned T     = 3,
  parameter int unsigned SLOTS = 4,
  localparam int unsigned CW   = $clog2(T + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_start_i,
  input  logic          in_data_i,
  output logic          in_busy_o,
  output logic          syn_start_o,
  output logic          syn_data_o,
  input  logic          syn_done_i,
  output logic          key_start_o,
  input  logic          key_busy_i,
  input  logic          key_done_i,
  input  logic [CW-1:0] key_err_count_i,
  output logic          err_start_o,
  input  logic          err_busy_i,
  input  logic          err_ready_i,
  input  logic          err_valid_i,
  input  logic          err_i,
  output logic          out_valid_o,
  output logic          out_data_o,
  output logic          out_first_o,
  output logic          out_last_o,
  output logic [CW-1:0] out_err_count_o,
  output logic          fault_o
);

  localparam int unsigned BW = $clog2(N);
  localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PW = $clog2(SLOTS);
  localparam int unsigned OW = PW + 1;
  localparam logic [BW-1:0] LastBit = BW'(N - 1);
  localparam logic [IW-1:0] LastIdx = IW'(K - 1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, key_ptr_q, out_ptr_q, out_ptr_d;
  logic [OW-1:0]   occ_q, occ_d, kp_q, kp_d;
  logic [K-1:0]    slot_q [SLOTS];
  logic [CW-1:0]   cnt_q  [SLOTS];
  logic [IW-1:0]   idx_q, idx_d, rd_idx;
  logic            active_q, active_d;
  logic            out_valid_q, out_valid_d, out_data_q, out_data_d;
  logic            out_first_q, out_first_d, out_last_q, out_last_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic            fault_q, fault_d;
  logic            alloc, wr_en, rd_bit, frame_done, err_fault;
  logic [BW-1:0]   wr_idx;

  // Input FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Input FSM: next state. The accepted in_start cycle carries bit 0.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (alloc) begin
          state_d   = StRecv;
          bit_cnt_d = BW'(1);
        end
      end
      StRecv: begin
        if (bit_cnt_q == LastBit) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
          wr_ptr_d  = wr_ptr_q + PW'(1);
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Input FSM: outputs
  always_comb begin
    in_busy_o = (state_q == StRecv) || (occ_q == OW'(SLOTS));
    alloc     = in_start_i && !in_busy_o;
    wr_idx    = (state_q == StIdle) ? '0 : bit_cnt_q;
    wr_en     = alloc || ((state_q == StRecv) && (bit_cnt_q < BW'(K)));
  end

  assign syn_start_o = alloc;
  assign syn_data_o  = in_data_i;
  assign key_start_o = syn_done_i && !key_busy_i;
  // A key_done with nothing past the syndrome stage is a fault and must not start the locator.
  assign err_start_o = key_done_i && !err_busy_i && (kp_q != '0);

  assign rd_idx = err_ready_i ? '0 : idx_q;

  always_comb begin
    rd_bit = 1'b0;
    for (int b = 0; b < K; b++) begin
      if (rd_idx == IW'(b)) rd_bit = slot_q[out_ptr_q][b];
    end
  end

  // Output path: err_ready opens a frame, err_valid carries the rest, bit K-1 closes it.
  always_comb begin
    out_valid_d = 1'b0;
    out_data_d  = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
    out_cnt_d   = '0;
    idx_d       = idx_q;
    active_d    = active_q;
    frame_done  = 1'b0;
    err_fault   = 1'b0;
    if (err_ready_i) begin
      if ((occ_q == '0) || active_q) begin
        err_fault = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = rd_bit ^ err_i;
        out_first_d = 1'b1;
        out_cnt_d   = cnt_q[out_ptr_q];
        if (K == 1) begin
          out_last_d = 1'b1;
          frame_done = 1'b1;
        end else begin
          idx_d    = IW'(1);
          active_d = 1'b1;
        end
      end
    end else if (err_valid_i) begin
      if ((occ_q == '0) || !active_q) begin
        err_fault = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = rd_bit ^ err_i;
        if (idx_q == LastIdx) begin
          out_last_d = 1'b1;
          frame_done = 1'b1;
          active_d   = 1'b0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
    end
    out_ptr_d = frame_done ? out_ptr_q + PW'(1) : out_ptr_q;
  end

  // Occupancy and key-stage pending counters; simultaneous inc/dec cancel.
  always_comb begin
    occ_d = occ_q;
    if (alloc && !frame_done)      occ_d = occ_q + OW'(1);
    else if (!alloc && frame_done) occ_d = occ_q - OW'(1);
    kp_d = kp_q;
    if (key_start_o && !err_start_o)      kp_d = kp_q + OW'(1);
    else if (!key_start_o && err_start_o) kp_d = kp_q - OW'(1);
    fault_d = fault_q | (in_start_i & in_busy_o) | err_fault | (key_done_i & (kp_q == '0));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      key_ptr_q   <= '0;
      out_ptr_q   <= '0;
      occ_q       <= '0;
      kp_q        <= '0;
      idx_q       <= '0;
      active_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_cnt_q   <= '0;
      fault_q     <= 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        slot_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      out_ptr_q   <= out_ptr_d;
      occ_q       <= occ_d;
      kp_q        <= kp_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_cnt_q   <= out_cnt_d;
      fault_q     <= fault_d;
      for (int b = 0; b < K; b++) begin
        if (wr_en && (wr_idx == BW'(b))) slot_q[wr_ptr_q][b] <= in_data_i;
      end
      if (err_start_o) begin
        cnt_q[key_ptr_q] <= key_err_count_i;
        key_ptr_q        <= key_ptr_q + PW'(1);
      end
    end
  end

  assign out_valid_o     = out_valid_q;
  assign out_data_o      = out_data_q;
  assign out_first_o     = out_first_q;
  assign out_last_o      = out_last_q;
  assign out_err_count_o = out_cnt_q;
  assign fault_o         = fault_q;

endmodule
